// File: rtl/inst_mem_loader.sv
// Boot loader for the instruction memory: takes a length-prefixed little-endian
// byte stream, writes one 32-bit word per cycle slot and releases the core when done.
module inst_mem_loader #(
    parameter int REG_SIZE       = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int NO_OF_WORDS    = MEM_SIZE_IN_KB * 1024 / 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [7:0]          byte_data_i,
    input  logic                byte_valid_i,
    output logic                byte_ready_o,
    output logic                we_o,
    output logic [REG_SIZE-1:0] waddr_o,
    output logic [REG_SIZE-1:0] wdata_o,
    output logic [REG_SIZE-1:0] word_cnt_o,
    output logic                core_hold_o,
    output logic                done_o,
    output logic                err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q;
    logic [1:0]          byte_cnt_q;
    logic [31:0]         shift_q;
    logic [31:0]         shift_d;
    logic [REG_SIZE-1:0] hdr_q;
    logic [REG_SIZE-1:0] word_cnt_q;
    logic [REG_SIZE-1:0] waddr_q;
    logic [REG_SIZE-1:0] wdata_q;
    logic                we_q;
    logic                ready_q;
    logic                hold_q;
    logic                done_q;
    logic                err_q;
    logic                accept;
    logic                last_byte;

    assign accept    = byte_valid_i && ready_q;
    assign last_byte = accept && (byte_cnt_q == 2'd3);
    // Bytes enter at the top so the first byte of a group ends up in bits [7:0].
    assign shift_d   = {byte_data_i, shift_q[31:8]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
            hdr_q      <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ready_q    <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (accept) begin
                shift_q    <= shift_d;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_HDR;
                        byte_cnt_q <= 2'd0;
                        word_cnt_q <= '0;
                        done_q     <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (last_byte) begin
                        if (shift_d == 32'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end else if (shift_d > 32'(NO_OF_WORDS)) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                            hdr_q   <= REG_SIZE'(shift_d);
                        end
                    end
                end
                S_DATA: begin
                    // word_cnt_q was bumped together with we_q, so equality marks the final write.
                    if (we_q && (word_cnt_q == hdr_q)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end else if (last_byte) begin
                        we_q       <= 1'b1;
                        waddr_q    <= {word_cnt_q[REG_SIZE-3:0], 2'b00};
                        wdata_q    <= REG_SIZE'(shift_d);
                        word_cnt_q <= word_cnt_q + REG_SIZE'(1);
                    end
                end
                S_DONE: begin
                    if (start_i) begin
                        state_q    <= S_HDR;
                        byte_cnt_q <= 2'd0;
                        word_cnt_q <= '0;
                        done_q     <= 1'b0;
                        hold_q     <= 1'b1;
                        ready_q    <= 1'b1;
                    end
                end
                S_ERR: begin
                    // Drain forever; only reset leaves this state.
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready_o = ready_q;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign word_cnt_o   = word_cnt_q;
    assign core_hold_o  = hold_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomised scoreboard bench for inst_mem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each we_o pulse.
module tb_inst_mem_loader;

    localparam int NW = 256;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  byte_data_i = 8'd0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic [31:0] word_cnt_o;
    logic        core_hold_o;
    logic        done_o;
    logic        err_o;

    inst_mem_loader dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_data_i  (byte_data_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .word_cnt_o   (word_cnt_o),
        .core_hold_o  (core_hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cnt;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          writes_seen = 0;
    int          last_we_cyc = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!rst_i && we_o) begin
            writes_seen++;
            last_we_cyc = cyc;
            $display("write addr=0x%08h data=0x%08h cnt=%0d", waddr_o, wdata_o, word_cnt_o);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h want no write", waddr_o, wdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", waddr_o, e.addr);
                chk("wdata", wdata_o, e.data);
                chk("word_cnt_at_write", word_cnt_o, e.cnt);
                chk("ready_during_write", {31'd0, byte_ready_o}, 32'd1);
            end
        end
    end

    task automatic check_reset();
        chk("rst_we", {31'd0, we_o}, 32'd0);
        chk("rst_waddr", waddr_o, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_word_cnt", word_cnt_o, 32'd0);
        chk("rst_hold", {31'd0, core_hold_o}, 32'd1);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk);
        check_reset();
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            byte_valid_i = 1'b0;
            byte_data_i  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        t = 0;
        while (!byte_ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            total++;
            bad++;
            $display("FAIL byte_accept_timeout: got ready 0 want 1");
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    // Streams header n followed by img[]; the model expects img[0..n-1] at i*4
    // unless n is zero or exceeds capacity.
    task automatic load(input logic [31:0] n, input int gapmode, input int start_at, input int limit);
        logic [7:0]  b;
        logic [31:0] w;
        int          gap;
        if (n != 0 && n <= NW)
            for (int i = 0; i < int'(n); i++)
                exp_q.push_back('{32'(i * 4), img[i], 32'(i + 1)});
        for (int j = 0; j < 4 + 4 * img.size(); j++) begin
            if (limit >= 0 && j >= limit) break;
            if (j < 4) begin
                b = n[8*j +: 8];
            end else begin
                w = img[(j - 4) / 4];
                b = w[8*((j - 4) % 4) +: 8];
            end
            gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
            start_i = (j == start_at);
            send_byte(b, gap);
            start_i = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input logic [31:0] n);
        int t = 0;
        while (!done_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_done"}, {31'd0, done_o}, 32'd1);
        chk({name, "_done_timing"}, 32'(cyc), 32'(last_we_cyc + 1));
        chk({name, "_hold"}, {31'd0, core_hold_o}, 32'd0);
        chk({name, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        chk({name, "_word_cnt"}, word_cnt_o, n);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int ws;

        @(negedge clk);
        do_reset();

        // Two known instructions followed by six random words.
        pulse_start();
        chk("hdr_ready", {31'd0, byte_ready_o}, 32'd1);
        chk("hdr_hold", {31'd0, core_hold_o}, 32'd1);
        img = {32'h0000_0013, 32'h0010_0093};
        for (int i = 0; i < 6; i++) img.push_back($urandom);
        load(32'd8, 0, -1, -1);
        wait_done("eight", 32'd8);

        // Reload from DONE with an empty image.
        pulse_start();
        chk("reload_hold", {31'd0, core_hold_o}, 32'd1);
        chk("reload_done", {31'd0, done_o}, 32'd0);
        chk("reload_cnt", word_cnt_o, 32'd0);
        ws = writes_seen;
        img.delete();
        load(32'd0, 0, -1, -1);
        chk("zero_done", {31'd0, done_o}, 32'd1);
        chk("zero_hold", {31'd0, core_hold_o}, 32'd0);
        chk("zero_cnt", word_cnt_o, 32'd0);
        chk("zero_writes", 32'(writes_seen), 32'(ws));

        // Single word with valid toggled every other cycle.
        pulse_start();
        img = {$urandom};
        load(32'd1, 1, -1, -1);
        wait_done("toggle", 32'd1);

        // start_i pulsed in the middle of DATA must be ignored.
        pulse_start();
        img.delete();
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        load(32'd3, 2, 6, -1);
        wait_done("start_in_data", 32'd3);

        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 6));
            pulse_start();
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            load(32'(n), 2, -1, -1);
            wait_done("random", 32'(n));
        end

        // Capacity boundary: exactly NW words, last write at 0x3FC.
        pulse_start();
        img.delete();
        for (int i = 0; i < NW; i++) img.push_back($urandom);
        load(32'(NW), 0, -1, -1);
        wait_done("full", 32'(NW));

        // Oversized header: drain bytes, no writes, sticky error.
        do_reset();
        pulse_start();
        ws = writes_seen;
        img = {$urandom, $urandom};
        load(32'h0000_0101, 2, -1, -1);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("err_flag", {31'd0, err_o}, 32'd1);
        chk("err_hold", {31'd0, core_hold_o}, 32'd1);
        chk("err_ready", {31'd0, byte_ready_o}, 32'd1);
        chk("err_done", {31'd0, done_o}, 32'd0);
        chk("err_writes", 32'(writes_seen), 32'(ws));
        chk("err_cnt", word_cnt_o, 32'd0);
        do_reset();

        // Reset after two of three words have been written.
        pulse_start();
        ws = writes_seen;
        img = {$urandom, $urandom, $urandom};
        load(32'd3, 0, -1, 14);
        n = 0;
        while (writes_seen < ws + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("writes_before_reset", 32'(writes_seen), 32'(ws + 2));
        do_reset();
        exp_q.delete();
        pulse_start();
        img = {$urandom};
        load(32'd1, 0, -1, -1);
        wait_done("after_reset", 32'd1);

        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
